gvp_bram_stream_srcs: RTL and testbench

- Data-capture packer for the GVP (generic vector probe) acquisition path.
- On each store trigger from the vector generator, snapshots up to 14 channel values, the GVP index and the 48-bit GVP time.
- Writes the selected words one per clock into a 16K x 32 BRAM through a native port-A write interface.
- Sits between the gvp vector engine (push_next, srcs and index come from it) and the dual-port stream BRAM read by the host.

---
 rtl/gvp_bram_stream_srcs.sv | 150 +++++++++++++++
 tb/tb_gvp_bram_stream_srcs.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gvp_bram_stream_srcs.sv
// GVP capture packer: snapshots probe sources on a push_next rising edge and
// streams header/data frames one word per clock into BRAM port A.
module gvp_bram_stream_srcs #(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] HDR_TAG = 16'hFEFE
) (
  input  logic              a2_clk,
  input  logic              reset,
  input  logic [31:0]       ch1s,
  input  logic [31:0]       ch2s,
  input  logic [31:0]       ch3s,
  input  logic [31:0]       ch4s,
  input  logic [31:0]       ch5s,
  input  logic [31:0]       ch6s,
  input  logic [31:0]       ch7s,
  input  logic [31:0]       ch8s,
  input  logic [31:0]       ch9s,
  input  logic [31:0]       chAs,
  input  logic [31:0]       chBs,
  input  logic [31:0]       chCs,
  input  logic [31:0]       chDs,
  input  logic [31:0]       chEs,
  input  logic [47:0]       gvp_time,
  input  logic [31:0]       srcs,
  input  logic [31:0]       index,
  input  logic [1:0]        push_next,
  output logic              BRAM_PORTA_clk,
  output logic [ADDR_W-1:0] BRAM_PORTA_addr,
  output logic [31:0]       BRAM_PORTA_din,
  output logic              BRAM_PORTA_en,
  output logic              BRAM_PORTA_we
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [13:0][31:0] ch_in, ch_q;
  logic [15:0]       srcs_q;
  logic [31:0]       index_q;
  logic [47:0]       time_q;
  logic [1:0]        push_q;
  logic [1:0]        state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [13:0]       mask_q, mask_d, mask_clr;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        idx;
  logic [31:0]       word;
  logic              trig, cap;
  logic              unused_ok;

  assign ch_in = {chEs, chDs, chCs, chBs, chAs, ch9s, ch8s,
                  ch7s, ch6s, ch5s, ch4s, ch3s, ch2s, ch1s};
  assign unused_ok = &{1'b0, srcs[31:16]};

  assign trig = (push_next != 2'd0) && (push_q == 2'd0);

  always_comb begin
    // lowest pending channel bit is emitted next
    idx = 4'd0;
    for (int i = 13; i >= 0; i--)
      if (mask_q[i]) idx = 4'(i);
    mask_clr = mask_q & ~(14'd1 << idx);

    word = '0;
    case (state_q)
      S_HDR: case (step_q)
        2'd0:    word = {HDR_TAG, srcs_q};
        2'd1:    word = index_q;
        2'd2:    word = time_q[31:0];
        default: word = {16'h0, time_q[47:32]};
      endcase
      S_DATA: case (step_q)
        2'd0:    word = {srcs_q, index_q[15:0]};
        2'd1:    word = time_q[31:0];
        2'd2:    word = {16'h0, time_q[47:32]};
        default: word = ch_q[idx];
      endcase
      default: word = '0;
    endcase

    state_d = state_q;
    step_d  = step_q;
    mask_d  = mask_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: if (trig) begin
        cap     = 1'b1;
        mask_d  = srcs[13:0];
        step_d  = 2'd0;
        state_d = push_next[1] ? S_HDR : S_DATA;
      end
      S_HDR: begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = S_DATA;
      end
      S_DATA: case (step_q)
        2'd0: begin
          if (srcs_q[15])   step_d  = 2'd1;
          else if (|mask_q) step_d  = 2'd3;
          else              state_d = S_IDLE;
        end
        2'd1: step_d = 2'd2;
        2'd2: begin
          if (|mask_q) step_d  = 2'd3;
          else         state_d = S_IDLE;
        end
        default: begin
          mask_d = mask_clr;
          if (mask_clr == 14'd0) state_d = S_IDLE;
        end
      endcase
      default: state_d = S_IDLE;
    endcase

    ptr_d = (state_q != S_IDLE) ? ptr_q + ADDR_W'(1) : ptr_q;
  end

  always_ff @(posedge a2_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      mask_q  <= 14'd0;
      ptr_q   <= '0;
      push_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      push_q  <= push_next;
    end
  end

  always_ff @(posedge a2_clk) begin
    if (cap) begin
      ch_q    <= ch_in;
      srcs_q  <= srcs[15:0];
      index_q <= index;
      time_q  <= gvp_time;
    end
  end

  assign BRAM_PORTA_clk  = a2_clk;
  assign BRAM_PORTA_en   = (state_q != S_IDLE);
  assign BRAM_PORTA_we   = BRAM_PORTA_en;
  assign BRAM_PORTA_addr = ptr_q;
  assign BRAM_PORTA_din  = BRAM_PORTA_en ? word : 32'h0;

endmodule

// File: tb/tb_gvp_bram_stream_srcs.sv
// Scoreboard bench for gvp_bram_stream_srcs: a frame model queues expected
// {addr,data} words at trigger time; a negedge monitor pops and compares.
module tb_gvp_bram_stream_srcs;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ch [14];
  logic [47:0] gvp_time;
  logic [31:0] srcs, index;
  logic [1:0]  push_next;
  logic        porta_clk, en, we;
  logic [13:0] addr;
  logic [31:0] din;

  logic [45:0] q[$];
  logic [13:0] mptr;
  int          vec_n = 0, err_n = 0, wr_cnt = 0;

  always #5 clk = ~clk;

  gvp_bram_stream_srcs dut (
    .a2_clk(clk), .reset(reset),
    .ch1s(ch[0]), .ch2s(ch[1]), .ch3s(ch[2]), .ch4s(ch[3]), .ch5s(ch[4]),
    .ch6s(ch[5]), .ch7s(ch[6]), .ch8s(ch[7]), .ch9s(ch[8]), .chAs(ch[9]),
    .chBs(ch[10]), .chCs(ch[11]), .chDs(ch[12]), .chEs(ch[13]),
    .gvp_time(gvp_time), .srcs(srcs), .index(index), .push_next(push_next),
    .BRAM_PORTA_clk(porta_clk), .BRAM_PORTA_addr(addr), .BRAM_PORTA_din(din),
    .BRAM_PORTA_en(en), .BRAM_PORTA_we(we)
  );

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      vec_n++;
      if (we !== en) begin
        err_n++;
        $display("FAIL we_eq_en: we=%b en=%b", we, en);
      end
      if (en === 1'b1) begin
        wr_cnt++;
        if (q.size() == 0) begin
          err_n++;
          $display("FAIL unexpected_write: addr=%0d din=%h, none required", addr, din);
        end else begin
          logic [45:0] e;
          e = q.pop_front();
          if ({addr, din} !== e) begin
            err_n++;
            $display("FAIL word: addr=%0d din=%h, required addr=%0d din=%h",
                     addr, din, e[45:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] d);
    q.push_back({mptr, d});
    mptr = mptr + 14'd1;
  endtask

  task automatic expect_frame(input logic [1:0] pn);
    logic [15:0] s;
    s = srcs[15:0];
    if (pn[1]) begin
      push_word({16'hFEFE, s});
      push_word(index);
      push_word(gvp_time[31:0]);
      push_word({16'h0, gvp_time[47:32]});
    end
    push_word({s, index[15:0]});
    if (s[15]) begin
      push_word(gvp_time[31:0]);
      push_word({16'h0, gvp_time[47:32]});
    end
    for (int i = 0; i < 14; i++)
      if (s[i]) push_word(ch[i]);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0) break;
      @(negedge clk); #1;
    end
    vec_n++;
    if (q.size() != 0) begin
      err_n++;
      $display("FAIL drain_timeout: %0d words pending, required 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_frame(input logic [1:0] pn, input int hold);
    expect_frame(pn);
    @(negedge clk) push_next = pn;
    repeat (hold) @(negedge clk);
    push_next = 2'd0;
    drain();
  endtask

  task automatic check_len(input string nm, input int got, input int req);
    vec_n++;
    if (got !== req) begin
      err_n++;
      $display("FAIL %s: %0d writes, required %0d", nm, got, req);
    end
  endtask

  task automatic setup();
    for (int i = 0; i < 14; i++) ch[i] = 32'(i + 1);
    srcs      = 32'h0000_000F;
    index     = 32'd4;
    gvp_time  = 48'h0001_0000_0010;
    push_next = 2'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
    mptr = 14'd0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setup();
    push_next = 2'd1;
    repeat (3) @(negedge clk);
    vec_n++;
    if ({en, we, addr, din} !== 48'h0) begin
      err_n++;
      $display("FAIL reset_outputs: en=%b we=%b addr=%0d din=%h, required all 0",
               en, we, addr, din);
    end
    push_next = 2'd0;
    apply_reset();
  endtask

  task automatic test_single();
    int base;
    setup();
    base = wr_cnt;
    expect_frame(2'd1);
    @(negedge clk) push_next = 2'd1;
    vec_n++;
    if (en !== 1'b0) begin
      err_n++;
      $display("FAIL latency_pre: en=%b on trigger cycle, required 0", en);
    end
    @(posedge clk); #1;
    vec_n++;
    if (en !== 1'b1 || addr !== 14'd0 || din !== 32'h000F0004) begin
      err_n++;
      $display("FAIL first_word: en=%b addr=%0d din=%h, required 1 0 000f0004",
               en, addr, din);
    end
    @(negedge clk) push_next = 2'd0;
    drain();
    check_len("single_len", wr_cnt - base, 5);
  endtask

  task automatic test_header();
    int base;
    setup();
    srcs = 32'h0000_800F;
    base = wr_cnt;
    expect_frame(2'd2);
    @(negedge clk) push_next = 2'd2;
    @(posedge clk); #1;
    vec_n++;
    if (din !== 32'hFEFE800F) begin
      err_n++;
      $display("FAIL header_tag: din=%h, required fefe800f", din);
    end
    @(negedge clk) push_next = 2'd0;
    drain();
    check_len("header_len", wr_cnt - base, 11);
  endtask

  task automatic test_hold();
    int base;
    setup();
    srcs = 32'h0000_3FFF;
    base = wr_cnt;
    do_frame(2'd1, 20);
    repeat (10) @(negedge clk);
    check_len("hold_len", wr_cnt - base, 15);
  endtask

  task automatic test_retrigger();
    int base;
    setup();
    srcs = 32'h0000_3FFF;
    base = wr_cnt;
    expect_frame(2'd1);
    @(negedge clk) push_next = 2'd1;
    @(negedge clk) begin push_next = 2'd0; ch[0] = 32'hDEAD_BEEF; end
    @(negedge clk) push_next = 2'd3;
    @(negedge clk) push_next = 2'd0;
    drain();
    repeat (25) @(negedge clk);
    check_len("retrigger_len", wr_cnt - base, 15);
    ch[0] = 32'd1;
  endtask

  task automatic test_reset_mid();
    setup();
    srcs = 32'h0000_3FFF;
    expect_frame(2'd1);
    @(negedge clk) push_next = 2'd1;
    @(posedge clk);
    @(negedge clk) push_next = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    vec_n++;
    if (en !== 1'b0 || addr !== 14'd0 || din !== 32'h0) begin
      err_n++;
      $display("FAIL reset_mid: en=%b addr=%0d din=%h, required 0 0 0", en, addr, din);
    end
    @(negedge clk);
    q.delete();
    mptr = 14'd0;
    reset = 1'b0;
    @(negedge clk);
    srcs = 32'h0000_000F;
    expect_frame(2'd1);
    @(negedge clk) push_next = 2'd1;
    @(posedge clk); #1;
    vec_n++;
    if (addr !== 14'd0) begin
      err_n++;
      $display("FAIL restart_addr: addr=%0d, required 0", addr);
    end
    @(negedge clk) push_next = 2'd0;
    drain();
  endtask

  task automatic test_wrap();
    apply_reset();
    setup();
    srcs = 32'h0000_3FFF;
    for (int f = 0; f < 1092; f++) do_frame(2'd1, 1);
    srcs = 32'h0;
    do_frame(2'd1, 1);
    do_frame(2'd1, 1);
    srcs = 32'h0000_000F;
    expect_frame(2'd1);
    @(negedge clk) push_next = 2'd1;
    @(posedge clk); #1;
    vec_n++;
    if (addr !== 14'd16382) begin
      err_n++;
      $display("FAIL wrap_start: addr=%0d, required 16382", addr);
    end
    @(negedge clk) push_next = 2'd0;
    drain();
    @(posedge clk); #1;
    vec_n++;
    if (addr !== 14'd3) begin
      err_n++;
      $display("FAIL wrap_end_ptr: addr=%0d, required 3", addr);
    end
  endtask

  initial begin
    mptr = 14'd0;
    test_reset();
    test_single();
    test_header();
    test_hold();
    test_retrigger();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
